// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes
// and the datapath select/ALU codes driven toward the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. master is the control unit,
// slave is the datapath/instruction-register side.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal_op, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal_op, state
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the instruction funct fields onto
// the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register ops honour bit30; addi with it set stays add.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I core. Outputs decode from the
// state register; only the memory handshake and the beq zero flag gate them.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master ctrl
);

    state_t     state_q;
    state_t     state_d;

    logic       pc_write_c;
    logic       adr_src_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [2:0] alu_control_c;
    logic       illegal_op_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RD2;
        alu_op_c     = ALUOP_ADD;
        illegal_op_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c   = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                if (ctrl.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes OldPC+imm so a taken beq has its target ready.
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_op_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read_c   = 1'b1;
                adr_src_c    = 1'b1;
                result_src_c = RES_ALUOUT;
                if (ctrl.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_RD2;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c  = SRCA_RD1;
                alu_src_b_c  = SRCB_RD2;
                alu_op_c     = ALUOP_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = ctrl.zero;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                state_d      = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_c),
        .funct3      (ctrl.funct3),
        .funct7b5    (ctrl.funct7b5),
        .op5         (ctrl.op[5]),
        .alu_control (alu_control_c)
    );

    // Reset masks every output immediately, so an in-flight store or writeback dies this cycle.
    assign ctrl.pc_write    = rst ? 1'b0 : pc_write_c;
    assign ctrl.adr_src     = rst ? 1'b0 : adr_src_c;
    assign ctrl.mem_read    = rst ? 1'b0 : mem_read_c;
    assign ctrl.mem_write   = rst ? 1'b0 : mem_write_c;
    assign ctrl.ir_write    = rst ? 1'b0 : ir_write_c;
    assign ctrl.reg_write   = rst ? 1'b0 : reg_write_c;
    assign ctrl.result_src  = rst ? 2'b00 : result_src_c;
    assign ctrl.alu_src_a   = rst ? 2'b00 : alu_src_a_c;
    assign ctrl.alu_src_b   = rst ? 2'b00 : alu_src_b_c;
    assign ctrl.alu_control = rst ? 3'b000 : alu_control_c;
    assign ctrl.imm_src     = rst ? 2'b00 : imm_src_of(ctrl.op);
    assign ctrl.illegal_op  = rst ? 1'b0 : illegal_op_c;
    assign ctrl.state       = rst ? 4'd0 : state_q;

endmodule
